// File: rtl/rr_fifo_arbiter.sv
// Four-to-one round-robin drain of upstream FIFOs into one downstream FIFO.
// Two-stage read pipeline matches the one-cycle upstream read latency.
module rr_fifo_arbiter #(
   parameter int DW = 6,
   parameter int N  = 4
) (
   input  logic            clk,
   input  logic            RESET_L,
   input  logic            en,
   input  logic [N-1:0]    fifo_empty_in,
   input  logic [N*DW-1:0] data_in,
   input  logic            out_al_full,
   input  logic            out_full,
   output logic [N-1:0]    fifo_rd_out,
   output logic            fifo_wr,
   output logic [DW-1:0]   data_out,
   output logic [1:0]      grant_idx,
   output logic [7:0]      word_cnt,
   output logic            err
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [N-1:0]    req_s;
   logic [2:0]      pick_s;
   logic            grant_s;
   logic [1:0]      winner_s;
   logic [1:0]      ptr_r;
   logic [1:0]      grant_idx_r;
   logic [1:0]      sel1_r;
   logic            v1_r;
   logic            v2_r;
   logic [DW-1:0]   lane_s;
   logic [DW-1:0]   data_out_r;
   logic [7:0]      word_cnt_r;
   logic            err_r;

   // First requester at or after ptr, wrapping; returns {found, index}.
   function automatic logic [2:0] rr_pick(input logic [N-1:0] req, input logic [1:0] ptr);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = N - 1; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign req_s  = ~fifo_empty_in;
   assign pick_s = rr_pick(req_s, ptr_r);

   // Next-state and grant decision; grants only while RUN and not almost-full.
   always_comb begin
      state_nxt_s = state_r;
      grant_s     = 1'b0;
      winner_s    = 2'b00;
      case (state_r)
         ST_IDLE: begin
            if (en) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (en) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
            if (!out_al_full && pick_s[2]) begin
               grant_s  = 1'b1;
               winner_s = pick_s[1:0];
            end else begin
               grant_s  = 1'b0;
               winner_s = 2'b00;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Select the upstream lane captured by stage 1.
   always_comb begin
      lane_s = data_in[DW*int'(sel1_r) +: DW];
   end

   assign fifo_rd_out = grant_s ? (N'(1) << winner_s) : {N{1'b0}};
   assign fifo_wr     = v2_r & ~out_full;
   assign data_out    = data_out_r;
   assign grant_idx   = grant_idx_r;
   assign word_cnt    = word_cnt_r;
   assign err         = err_r;

   // FSM state register.
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Round-robin pointer moves past the winner on every grant.
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         ptr_r       <= 2'b00;
         grant_idx_r <= 2'b00;
      end else if (grant_s) begin
         ptr_r       <= winner_s + 2'd1;
         grant_idx_r <= winner_s;
      end
   end

   // Read pipeline: stage 1 remembers the source, stage 2 captures its word.
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         v1_r       <= 1'b0;
         v2_r       <= 1'b0;
         sel1_r     <= 2'b00;
         data_out_r <= {DW{1'b0}};
      end else begin
         v1_r <= grant_s;
         v2_r <= v1_r;
         if (grant_s) begin
            sel1_r <= winner_s;
         end
         if (v1_r) begin
            data_out_r <= lane_s;
         end
      end
   end

   // Push counter and sticky overflow flag (a word arriving into a full FIFO is lost).
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         word_cnt_r <= 8'd0;
         err_r      <= 1'b0;
      end else begin
         if (fifo_wr) begin
            word_cnt_r <= word_cnt_r + 8'd1;
         end
         if (v2_r && out_full) begin
            err_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Scoreboard bench for rr_fifo_arbiter: upstream FIFOs modelled as queues,
// expected downstream words queued in round-robin order and compared on push.
module tb_rr_fifo_arbiter;

   logic        clk = 1'b0;
   logic        RESET_L;
   logic        en;
   logic [3:0]  fifo_empty_in;
   logic [23:0] data_in;
   logic        out_al_full;
   logic        out_full;
   logic [3:0]  fifo_rd_out;
   logic        fifo_wr;
   logic [5:0]  data_out;
   logic [1:0]  grant_idx;
   logic [7:0]  word_cnt;
   logic        err;

   logic [5:0] up_q [4][$];
   logic [5:0] exp_q[$];
   int         gcyc_q[$];
   int         gnt_log[$];
   int         pcyc_q[$];
   int         n_chk = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         push_cnt = 0;
   logic [3:0] last_rd;
   logic       last_wr;

   always #5 clk = ~clk;

   rr_fifo_arbiter dut (
      .clk          (clk),
      .RESET_L      (RESET_L),
      .en           (en),
      .fifo_empty_in(fifo_empty_in),
      .data_in      (data_in),
      .out_al_full  (out_al_full),
      .out_full     (out_full),
      .fifo_rd_out  (fifo_rd_out),
      .fifo_wr      (fifo_wr),
      .data_out     (data_out),
      .grant_idx    (grant_idx),
      .word_cnt     (word_cnt),
      .err          (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic upd_empty();
      for (int i = 0; i < 4; i++) fifo_empty_in[i] = (up_q[i].size() == 0);
   endtask

   // One clock: sample at negedge, score pushes, then model upstream pops after the edge.
   task automatic cycle();
      @(negedge clk);
      last_rd = fifo_rd_out;
      last_wr = fifo_wr;
      check_eq("onehot", 32'($onehot0(last_rd)), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (last_rd[i]) begin
            gnt_log.push_back(i);
            gcyc_q.push_back(cyc);
         end
      end
      if (last_wr) begin
         push_cnt++;
         pcyc_q.push_back(cyc);
         if (exp_q.size() == 0) check_eq("sb_extra", 32'd1, 32'd0);
         else check_eq("data", 32'(data_out), 32'(exp_q.pop_front()));
         if (gcyc_q.size() == 0) check_eq("lat_extra", 32'd1, 32'd0);
         else check_eq("latency", 32'(cyc - gcyc_q.pop_front()), 32'd2);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (last_rd[i]) begin
            if (up_q[i].size() > 0) data_in[i*6 +: 6] = up_q[i].pop_front();
            else check_eq("pop_empty", 32'd1, 32'd0);
         end
      end
      upd_empty();
      cyc++;
   endtask

   task automatic clear_logs();
      exp_q.delete();
      gcyc_q.delete();
      gnt_log.delete();
      pcyc_q.delete();
      push_cnt = 0;
   endtask

   task automatic check_zero(input string pfx);
      check_eq({pfx, "_rd"},   32'(fifo_rd_out), 32'd0);
      check_eq({pfx, "_wr"},   32'(fifo_wr),     32'd0);
      check_eq({pfx, "_dout"}, 32'(data_out),    32'd0);
      check_eq({pfx, "_gidx"}, 32'(grant_idx),   32'd0);
      check_eq({pfx, "_cnt"},  32'(word_cnt),    32'd0);
      check_eq({pfx, "_err"},  32'(err),         32'd0);
   endtask

   task automatic do_reset();
      RESET_L     = 1'b0;
      en          = 1'b0;
      out_al_full = 1'b0;
      out_full    = 1'b0;
      data_in     = 24'd0;
      for (int i = 0; i < 4; i++) up_q[i].delete();
      upd_empty();
      #1;
      check_zero("rst");
      repeat (2) cycle();
      RESET_L = 1'b1;
      clear_logs();
   endtask

   // Load n random words per FIFO; with equal depths the drain order is 0,1,2,3 repeated.
   task automatic load_all(input int n);
      for (int j = 0; j < n; j++)
         for (int i = 0; i < 4; i++) up_q[i].push_back(6'($urandom_range(0, 63)));
      for (int j = 0; j < n; j++)
         for (int i = 0; i < 4; i++) exp_q.push_back(up_q[i][j]);
      upd_empty();
   endtask

   task automatic run_until_rd(input logic [3:0] want, input int max);
      int k = 0;
      do begin
         cycle();
         k++;
      end while (last_rd != want && k < max);
      if (last_rd != want) check_eq("timeout_rd", 32'(last_rd), 32'(want));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int k;
      bit seen255;
      RESET_L = 1'b0;

      // 1: single FIFO with two words
      do_reset();
      up_q[2].push_back(6'h15);
      up_q[2].push_back(6'h2A);
      exp_q.push_back(6'h15);
      exp_q.push_back(6'h2A);
      upd_empty();
      en = 1'b1;
      repeat (8) cycle();
      check_eq("t1_ngnt", 32'(gnt_log.size()), 32'd2);
      check_eq("t1_g0", 32'(gnt_log[0]), 32'd2);
      check_eq("t1_g1", 32'(gnt_log[1]), 32'd2);
      check_eq("t1_push", 32'(push_cnt), 32'd2);
      check_eq("t1_cnt", 32'(word_cnt), 32'd2);
      check_eq("t1_gidx", 32'(grant_idx), 32'd2);

      // 2: all four with three words, fair order and back-to-back pushes
      do_reset();
      load_all(3);
      en = 1'b1;
      repeat (20) cycle();
      check_eq("t2_ngnt", 32'(gnt_log.size()), 32'd12);
      for (int i = 0; i < 12; i++) check_eq("t2_order", 32'(gnt_log[i]), 32'(i % 4));
      check_eq("t2_npush", 32'(pcyc_q.size()), 32'd12);
      check_eq("t2_b2b", 32'(pcyc_q[11] - pcyc_q[0]), 32'd11);
      check_eq("t2_cnt", 32'(word_cnt), 32'd12);

      // 3: almost-full backpressure right after a grant to FIFO1
      do_reset();
      load_all(2);
      en = 1'b1;
      run_until_rd(4'b0010, 10);
      out_al_full = 1'b1;
      p0 = push_cnt;
      repeat (5) begin
         cycle();
         check_eq("t3_hold_rd", 32'(last_rd), 32'd0);
      end
      check_eq("t3_inflight", 32'(push_cnt - p0), 32'd2);
      out_al_full = 1'b0;
      cycle();
      check_eq("t3_resume", 32'(last_rd), 32'b0100);
      repeat (10) cycle();
      check_eq("t3_cnt", 32'(word_cnt), 32'd8);
      check_eq("t3_sb_left", 32'(exp_q.size()), 32'd0);

      // 4: overflow drops the word and sets a sticky error
      do_reset();
      up_q[0].push_back(6'h11);
      exp_q.push_back(6'h11);
      upd_empty();
      en = 1'b1;
      run_until_rd(4'b0001, 5);
      cycle();
      out_full = 1'b1;
      cycle();
      check_eq("t4_wr", 32'(last_wr), 32'd0);
      check_eq("t4_err", 32'(err), 32'd1);
      out_full = 1'b0;
      repeat (5) cycle();
      check_eq("t4_err_sticky", 32'(err), 32'd1);
      check_eq("t4_cnt", 32'(word_cnt), 32'd0);
      do_reset();

      // 5: reset one cycle after a grant discards in-flight data and resets ptr
      up_q[2].push_back(6'h2C);
      upd_empty();
      en = 1'b1;
      run_until_rd(4'b0100, 5);
      RESET_L = 1'b0;
      #1;
      check_zero("t5");
      clear_logs();
      repeat (2) cycle();
      en = 1'b0;
      RESET_L = 1'b1;
      repeat (4) cycle();
      check_eq("t5_nopush", 32'(push_cnt), 32'd0);
      up_q[1].push_back(6'h31);
      up_q[3].push_back(6'h33);
      exp_q.push_back(6'h31);
      exp_q.push_back(6'h33);
      upd_empty();
      en = 1'b1;
      repeat (8) cycle();
      check_eq("t5_first", 32'(gnt_log[0]), 32'd1);
      check_eq("t5_cnt", 32'(word_cnt), 32'd2);

      // 6a: 256 pushes wrap the counter
      do_reset();
      load_all(64);
      en = 1'b1;
      seen255 = 1'b0;
      for (int c = 0; c < 280; c++) begin
         cycle();
         if (push_cnt == 255 && !seen255) begin
            seen255 = 1'b1;
            check_eq("t6_cnt255", 32'(word_cnt), 32'd255);
         end
      end
      check_eq("t6_push", 32'(push_cnt), 32'd256);
      check_eq("t6_wrap", 32'(word_cnt), 32'd0);

      // 6b: en dropped mid-stream; grant in that cycle counts, then 2 drain pushes
      do_reset();
      load_all(4);
      en = 1'b1;
      k = 0;
      while (gnt_log.size() < 6 && k < 20) begin
         cycle();
         k++;
      end
      if (gnt_log.size() < 6) check_eq("timeout_gnt", 32'(gnt_log.size()), 32'd6);
      en = 1'b0;
      cycle();
      check_eq("t6_last_gnt", 32'(last_rd != 4'd0), 32'd1);
      p0 = push_cnt;
      repeat (5) begin
         cycle();
         check_eq("t6_idle_rd", 32'(last_rd), 32'd0);
      end
      check_eq("t6_drain", 32'(push_cnt - p0), 32'd2);
      check_eq("t6_cnt", 32'(word_cnt), 32'd7);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rr_fifo_arbiter.md
Name: rr_fifo_arbiter

Overview:
- Four-to-one round-robin arbiter that drains four upstream 6-bit FIFOs and writes one downstream 6-bit FIFO.
- Upstream side: drives each FIFO's fifo_rd and takes its fifo_empty and data_out.
- Downstream side: drives fifo_wr and data_in of the next FIFO, and obeys that FIFO's al_full backpressure.
- Sits directly upstream of the egress FIFO in the datapath.

Parameters:
DW, 6, data word width
N, 4, number of upstream FIFOs (fixed at 4; ptr and grant_idx are 2 bits)

Ports:
clk  input  1  single clock; everything is rising-edge
RESET_L  input  1  reset, asynchronous assert, active-low
en  input  1  arbitration enable, sampled synchronously
fifo_empty_in  input  4  fifo_empty of upstream FIFO i on bit i
data_in  input  24  data_out of upstream FIFO i on bits [6i+5:6i]
out_al_full  input  1  al_full of the downstream FIFO
out_full  input  1  fifo_full of the downstream FIFO
fifo_rd_out  output  4  one-hot pop to upstream FIFO i
fifo_wr  output  1  push to the downstream FIFO
data_out  output  6  word to the downstream FIFO, registered
grant_idx  output  2  index of the last granted FIFO, registered
word_cnt  output  8  count of words pushed, wraps 255->0
err  output  1  sticky overflow error

Behaviour:
Interface:
- One clock, clk. Reset RESET_L is asynchronous and active-low.

Reset (RESET_L=0, immediate):
- fifo_wr=0, data_out=0, grant_idx=0, word_cnt=0, err=0.
- fifo_rd_out=0. Internal ptr=0. Pipeline valid bits cleared. FSM=IDLE.
- Reset in mid-operation discards in-flight words; no push follows release.

FSM:
- IDLE: no grants. Goes to RUN on the first edge with en=1.
- RUN: arbitrates every cycle. Goes to IDLE on the first edge with en=0.
- The pipeline keeps draining after leaving RUN: up to 2 pushes still complete.

Grant (combinational, in RUN only):
- req = ~fifo_empty_in.
- If out_al_full=0 and req!=0, the winner is the first set req bit searching ptr, ptr+1, ... mod 4.
- fifo_rd_out = onehot(winner); otherwise fifo_rd_out=0.
- At most one bit of fifo_rd_out is high in any cycle.

Pointer:
- On a grant edge, ptr <= winner+1 mod 4 and grant_idx <= winner.
- With no grant, ptr and grant_idx hold.

Pipeline (upstream FIFO data_out is valid the cycle after fifo_rd is sampled):
- Stage 1, edge after grant cycle T: sel1 <= winner, v1 <= grant.
- Stage 2, next edge: v2 <= v1 and data_out <= data_in[sel1]. fifo_wr = v2 & ~out_full.
- Read-to-write latency: fifo_rd high in cycle T gives fifo_wr high in cycle T+2.
- Throughput: 1 word/cycle sustained.

Backpressure:
- Grants are gated only by out_al_full.
- The downstream al_full threshold is configured to leave at least 2 free entries, covering the 2 in-flight words.

Overflow:
- If v2=1 and out_full=1: the push is suppressed, the word is dropped, and err <= 1.
- err is cleared only by reset.

Counter:
- word_cnt increments on each cycle with fifo_wr=1; it wraps modulo 256.

Simultaneous events:
- out_al_full rising in the same cycle as a request: no grant that cycle.
- en falling in a grant cycle: the grant in that cycle still counts, since the FSM is still RUN.

Fairness:
- With all four requesting continuously, the grant order is 0,1,2,3,0,...
- No FIFO waits more than 3 grants.

Test Plan:
1. Reset, en=1, only FIFO2 holds {0x15,0x2A} -> fifo_rd_out=0100 for 2 cycles; fifo_wr in cycles T+2,T+3 with data_out 0x15 then 0x2A; word_cnt=2; grant_idx=2.
2. All four FIFOs hold 3 words each, out_al_full=0 -> grant sequence 0,1,2,3 repeated 3 times; 12 pushes back-to-back; word_cnt=12.
3. Grant to FIFO1 then out_al_full=1 for 5 cycles with all FIFOs non-empty -> fifo_rd_out=0 for those 5 cycles; the 2 in-flight words are still pushed; the next grant after release goes to FIFO2.
4. Force out_full=1 while v2=1 -> fifo_wr=0, err=1, and err stays 1 until RESET_L is pulsed low.
5. RESET_L asserted low one cycle after a grant -> all outputs 0 immediately; no fifo_wr after release; ptr=0, so the first grant goes to the lowest non-empty index.
6. Push 256 words -> word_cnt wraps to 0; drop en during a stream -> at most 2 further pushes, then fifo_rd_out stays 0.
